// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 responder: FSM states, phase
// lengths in microseconds, frame width and the checksum helper.
package dht11_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HOST_LOW  = 3'd1,
        S_RESP_DLY  = 3'd2,
        S_RESP_LOW  = 3'd3,
        S_RESP_HIGH = 3'd4,
        S_BIT_LOW   = 3'd5,
        S_BIT_HIGH  = 3'd6,
        S_END_LOW   = 3'd7
    } dht11_state_e;

    localparam int RESP_LOW_US  = 80;
    localparam int RESP_HIGH_US = 80;
    localparam int BIT_LOW_US   = 50;
    localparam int BIT0_HIGH_US = 26;
    localparam int BIT1_HIGH_US = 70;
    localparam int END_LOW_US   = 50;
    localparam int FRAME_BITS   = 40;

    function automatic logic [7:0] dht11_cksum(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c, input logic [7:0] d);
        logic [9:0] sum;
        sum = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
        return sum[7:0];
    endfunction

endpackage

// File: rtl/dht11_sync.sv
// Two-flop synchronizer for the single-wire bus; resets to 1 because the
// idle bus is pulled high.
module dht11_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Resynchronise the asynchronous bus level into the clock domain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/dht11_responder.sv
// DHT11 single-wire responder: accepts a host start pulse and answers with the
// preamble and a 40-bit frame. Optional macro DHT11_RESP_FAULT_EN adds fault_cksum.
module dht11_responder
    import dht11_pkg::*;
#(
    parameter int CLK_PER_US   = 50,
    parameter int START_MIN_US = 18000,
    parameter int RESP_DLY_US  = 30
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        data,
    input  logic [7:0] hum_int,
    input  logic [7:0] hum_dec,
    input  logic [7:0] temp_int,
    input  logic [7:0] temp_dec,
`ifdef DHT11_RESP_FAULT_EN
    input  logic       fault_cksum,
`endif
    output logic       busy,
    output logic       frame_done,
    output logic       short_start
);
    localparam int START_CYC = START_MIN_US * CLK_PER_US;
    localparam int CNT_W     = $clog2(START_CYC) + 1;

    dht11_state_e            r_state;
    dht11_state_e            w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_phase_cyc;
    logic                    w_phase_end;
    logic [5:0]              r_bit_idx;
    logic [FRAME_BITS-1:0]   r_frame;
    logic                    r_drive_low;
    logic                    r_busy;
    logic                    r_frame_done;
    logic                    r_short_start;
    logic                    w_rx;
    logic                    w_load;
    logic                    w_short;
    logic                    w_done;
    logic                    w_bit_adv;
    logic [7:0]              w_ck_mask;

    dht11_sync u_sync (
        .i_clk (clk),
        .i_rst (reset),
        .i_d   (data),
        .o_q   (w_rx)
    );

`ifdef DHT11_RESP_FAULT_EN
    assign w_ck_mask = {8{fault_cksum}};
`else
    assign w_ck_mask = 8'h00;
`endif

    assign data = r_drive_low ? 1'b0 : 1'bz;

    // Length in cycles of the timed phase the FSM is currently in.
    always_comb begin
        w_phase_cyc = '0;
        case (r_state)
            S_RESP_DLY:  w_phase_cyc = CNT_W'(RESP_DLY_US * CLK_PER_US);
            S_RESP_LOW:  w_phase_cyc = CNT_W'(RESP_LOW_US * CLK_PER_US);
            S_RESP_HIGH: w_phase_cyc = CNT_W'(RESP_HIGH_US * CLK_PER_US);
            S_BIT_LOW:   w_phase_cyc = CNT_W'(BIT_LOW_US * CLK_PER_US);
            S_BIT_HIGH:  w_phase_cyc = r_frame[FRAME_BITS-1] ? CNT_W'(BIT1_HIGH_US * CLK_PER_US)
                                                             : CNT_W'(BIT0_HIGH_US * CLK_PER_US);
            S_END_LOW:   w_phase_cyc = CNT_W'(END_LOW_US * CLK_PER_US);
            default:     w_phase_cyc = '0;
        endcase
    end

    assign w_phase_end = (r_cnt == w_phase_cyc - CNT_W'(1));

    // Next-state and event decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_short     = 1'b0;
        w_done      = 1'b0;
        w_bit_adv   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx) w_state_nxt = S_HOST_LOW;
                else       w_state_nxt = S_IDLE;
            end
            S_HOST_LOW: begin
                // cnt trails the low time by the IDLE cycle that saw the falling edge
                if (w_rx) begin
                    if (r_cnt >= CNT_W'(START_CYC - 1)) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_RESP_DLY;
                    end else begin
                        w_short     = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_HOST_LOW;
                end
            end
            S_RESP_DLY: begin
                if (w_phase_end) w_state_nxt = S_RESP_LOW;
                else             w_state_nxt = S_RESP_DLY;
            end
            S_RESP_LOW: begin
                if (w_phase_end) w_state_nxt = S_RESP_HIGH;
                else             w_state_nxt = S_RESP_LOW;
            end
            S_RESP_HIGH: begin
                if (w_phase_end) w_state_nxt = S_BIT_LOW;
                else             w_state_nxt = S_RESP_HIGH;
            end
            S_BIT_LOW: begin
                if (w_phase_end) w_state_nxt = S_BIT_HIGH;
                else             w_state_nxt = S_BIT_LOW;
            end
            S_BIT_HIGH: begin
                if (w_phase_end) begin
                    if (r_bit_idx < 6'(FRAME_BITS - 1)) begin
                        w_bit_adv   = 1'b1;
                        w_state_nxt = S_BIT_LOW;
                    end else begin
                        w_state_nxt = S_END_LOW;
                    end
                end else begin
                    w_state_nxt = S_BIT_HIGH;
                end
            end
            S_END_LOW: begin
                if (w_phase_end) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_END_LOW;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, counter, frame shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bit_idx     <= 6'd0;
            r_frame       <= '0;
            r_drive_low   <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_short_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if (r_cnt != '1)       r_cnt <= r_cnt + CNT_W'(1);
            else                        r_cnt <= r_cnt;
            if (w_load) begin
                r_frame   <= {hum_int, hum_dec, temp_int, temp_dec,
                              dht11_cksum(hum_int, hum_dec, temp_int, temp_dec) ^ w_ck_mask};
                r_bit_idx <= 6'd0;
            end else if (w_bit_adv) begin
                r_frame   <= {r_frame[FRAME_BITS-2:0], 1'b0};
                r_bit_idx <= r_bit_idx + 6'd1;
            end else begin
                r_frame   <= r_frame;
                r_bit_idx <= r_bit_idx;
            end
            r_drive_low   <= (r_state == S_RESP_LOW) || (r_state == S_BIT_LOW) ||
                             (r_state == S_END_LOW);
            r_busy        <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_HOST_LOW);
            r_frame_done  <= w_done;
            r_short_start <= w_short;
        end
    end

    assign busy        = r_busy;
    assign frame_done  = r_frame_done;
    assign short_start = r_short_start;
endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench for dht11_responder with scaled timing (1 clk/us, 100 us
// start threshold); the bus waveform is captured and compared with a frame model.
module tb_dht11_responder;
    localparam int CPU  = 1;
    localparam int SMIN = 100;
    localparam int RDLY = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       host_low = 1'b0;
    logic [7:0] hum_int = 8'h00, hum_dec = 8'h00, temp_int = 8'h00, temp_dec = 8'h00;
`ifdef DHT11_RESP_FAULT_EN
    logic       fault_cksum = 1'b0;
`endif
    logic       busy, frame_done, short_start;
    wire        data;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;
    int ss_cnt = 0;
    int cap_low[$];
    int cap_high[$];
    int cap_dly;
    int cap_busy_gap;
    bit cap_timeout;

    pullup (data);
    assign data = host_low ? 1'b0 : 1'bz;

    dht11_responder #(.CLK_PER_US(CPU), .START_MIN_US(SMIN), .RESP_DLY_US(RDLY)) dut (
        .clk         (clk),
        .reset       (reset),
        .data        (data),
        .hum_int     (hum_int),
        .hum_dec     (hum_dec),
        .temp_int    (temp_int),
        .temp_dec    (temp_dec),
`ifdef DHT11_RESP_FAULT_EN
        .fault_cksum (fault_cksum),
`endif
        .busy        (busy),
        .frame_done  (frame_done),
        .short_start (short_start)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)  fd_cnt++;
        if (short_start) ss_cnt++;
    end

    function automatic logic [39:0] model_frame(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d,
                                                input bit flt);
        int s;
        logic [7:0] ck;
        s  = int'(a) + int'(b) + int'(c) + int'(d);
        ck = 8'(s % 256);
        if (flt) ck = ~ck;
        return {a, b, c, d, ck};
    endfunction

    // Count waveform segments deviating more than one cycle from the ideal frame.
    function automatic int wave_errs(input logic [39:0] f);
        int e = 0;
        int exp_low[42];
        int exp_high[41];
        if (cap_low.size() != 42 || cap_high.size() != 41) return 999;
        exp_low[0]  = 80;
        exp_high[0] = 80;
        for (int i = 0; i < 40; i++) begin
            exp_low[i+1]  = 50;
            exp_high[i+1] = f[39-i] ? 70 : 26;
        end
        exp_low[41] = 50;
        for (int i = 0; i < 42; i++) if (cap_low[i] - exp_low[i] > 1 || exp_low[i] - cap_low[i] > 1) e++;
        for (int i = 0; i < 41; i++) if (cap_high[i] - exp_high[i] > 1 || exp_high[i] - cap_high[i] > 1) e++;
        return e;
    endfunction

    function automatic logic [39:0] decode();
        logic [39:0] v = '0;
        if (cap_high.size() != 41) return '0;
        for (int i = 0; i < 40; i++) v[39-i] = (cap_high[i+1] > 48);
        return v;
    endfunction

    task automatic host_start(input int low_cyc);
        @(negedge clk);
        host_low = 1'b1;
        repeat (low_cyc) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Record bus run lengths from host release until the bus stays idle.
    task automatic capture();
        bit lvl, prev;
        int run;
        int n;
        cap_low.delete();
        cap_high.delete();
        cap_dly = 0;
        cap_busy_gap = 0;
        cap_timeout = 1'b1;
        prev = 1'b1;
        run = 0;
        for (n = 0; n < 8000; n++) begin
            @(negedge clk);
            lvl = (data !== 1'b0);
            if (lvl == prev) run++;
            else begin
                if (prev) begin
                    if (cap_low.size() == 0) cap_dly = run;
                    else cap_high.push_back(run);
                end else cap_low.push_back(run);
                prev = lvl;
                run = 1;
            end
            if (!lvl && cap_high.size() < 41 && !busy) cap_busy_gap++;
            if (prev && run > 300 && cap_low.size() > 0) begin
                cap_timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (data !== 1'b1) begin errors++; $display("FAIL reset_bus: got %b expected 1", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", frame_done); end
        checks++; if (short_start !== 1'b0) begin errors++; $display("FAIL reset_short: got %b expected 0", short_start); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_nominal();
        logic [39:0] exp_f;
        int fd0;
        hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h05;
        exp_f = model_frame(hum_int, hum_dec, temp_int, temp_dec, 1'b0);
        fd0 = fd_cnt;
        host_start(SMIN);
        capture();
        checks++; if (cap_timeout) begin errors++; $display("FAIL nom_timeout: bus never returned idle"); end
        checks++; if (cap_dly < RDLY + 1 || cap_dly > RDLY + 4) begin errors++; $display("FAIL nom_resp_dly: got %0d expected %0d..%0d", cap_dly, RDLY + 1, RDLY + 4); end
        checks++; if (decode() !== exp_f) begin errors++; $display("FAIL nom_frame: got %h expected %h", decode(), exp_f); end
        checks++; if (exp_f[7:0] !== 8'h55) begin errors++; $display("FAIL nom_model_ck: got %h expected 55", exp_f[7:0]); end
        checks++; if (wave_errs(exp_f) !== 0) begin errors++; $display("FAIL nom_timing: got %0d bad segments expected 0", wave_errs(exp_f)); end
        checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL nom_done: got %0d pulses expected 1", fd_cnt - fd0); end
        checks++; if (cap_busy_gap !== 0) begin errors++; $display("FAIL nom_busy: got %0d low cycles expected 0", cap_busy_gap); end
    endtask

    task automatic test_short_start();
        int ss0;
        bit drove = 1'b0;
        bit busy_seen = 1'b0;
        ss0 = ss_cnt;
        host_start(SMIN - 1);
        repeat (300) begin
            @(negedge clk);
            if (data === 1'b0) drove = 1'b1;
            if (busy) busy_seen = 1'b1;
        end
        checks++; if (ss_cnt - ss0 !== 1) begin errors++; $display("FAIL short_pulse: got %0d pulses expected 1", ss_cnt - ss0); end
        checks++; if (drove !== 1'b0) begin errors++; $display("FAIL short_bus: got driven low expected released"); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL short_busy: got 1 expected 0"); end
    endtask

    task automatic test_cksum_wrap();
        logic [39:0] exp_f;
        hum_int = 8'hFF; hum_dec = 8'hFF; temp_int = 8'h01; temp_dec = 8'h02;
        exp_f = model_frame(hum_int, hum_dec, temp_int, temp_dec, 1'b0);
        host_start(SMIN + 50);
        capture();
        checks++; if (decode() !== exp_f) begin errors++; $display("FAIL wrap_frame: got %h expected %h", decode(), exp_f); end
        checks++; if (decode()[7:0] !== 8'h01) begin errors++; $display("FAIL wrap_ck: got %h expected 01", decode()[7:0]); end
        checks++; if (wave_errs(exp_f) !== 0) begin errors++; $display("FAIL wrap_timing: got %0d bad segments expected 0", wave_errs(exp_f)); end
    endtask

    task automatic test_snapshot();
        logic [39:0] exp_f;
        hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h05;
        exp_f = model_frame(8'h37, 8'h00, 8'h19, 8'h05, 1'b0);
        host_start(SMIN);
        fork
            capture();
            begin
                repeat (70) @(negedge clk);
                hum_int = 8'h40;
            end
        join
        checks++; if (decode() !== exp_f) begin errors++; $display("FAIL snap_frame: got %h expected %h", decode(), exp_f); end
        checks++; if (wave_errs(exp_f) !== 0) begin errors++; $display("FAIL snap_timing: got %0d bad segments expected 0", wave_errs(exp_f)); end
    endtask

    task automatic test_reset_mid_frame();
        int falls = 0;
        bit prev = 1'b1;
        logic [39:0] exp_f;
        hum_int = 8'hA5; hum_dec = 8'h3C; temp_int = 8'h7E; temp_dec = 8'h81;
        host_start(SMIN + 20);
        for (int n = 0; n < 4000 && falls < 22; n++) begin
            @(negedge clk);
            if (prev && data === 1'b0) falls++;
            prev = (data !== 1'b0);
        end
        checks++; if (falls !== 22) begin errors++; $display("FAIL rst_reach_bit20: got %0d falls expected 22", falls); end
        repeat (10) @(negedge clk);
        checks++; if (data !== 1'b0) begin errors++; $display("FAIL rst_pre_low: got %b expected 0", data); end
        reset = 1'b1;
        #1;
        checks++; if (data !== 1'b1) begin errors++; $display("FAIL rst_release: got %b expected 1", data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (frame_done !== 1'b0 || short_start !== 1'b0) begin errors++; $display("FAIL rst_pulses: got %b%b expected 00", frame_done, short_start); end
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        exp_f = model_frame(hum_int, hum_dec, temp_int, temp_dec, 1'b0);
        host_start(SMIN);
        capture();
        checks++; if (decode() !== exp_f) begin errors++; $display("FAIL rst_next_frame: got %h expected %h", decode(), exp_f); end
        checks++; if (wave_errs(exp_f) !== 0) begin errors++; $display("FAIL rst_next_timing: got %0d bad segments expected 0", wave_errs(exp_f)); end
    endtask

    task automatic test_random();
        logic [39:0] exp_f;
        int fd0;
        for (int k = 0; k < 3; k++) begin
            hum_int  = 8'($urandom_range(0, 255));
            hum_dec  = 8'($urandom_range(0, 255));
            temp_int = 8'($urandom_range(0, 255));
            temp_dec = 8'($urandom_range(0, 255));
            exp_f = model_frame(hum_int, hum_dec, temp_int, temp_dec, 1'b0);
            fd0 = fd_cnt;
            host_start(SMIN + int'($urandom_range(0, 300)));
            capture();
            checks++; if (decode() !== exp_f) begin errors++; $display("FAIL rand%0d_frame: got %h expected %h", k, decode(), exp_f); end
            checks++; if (wave_errs(exp_f) !== 0) begin errors++; $display("FAIL rand%0d_timing: got %0d bad segments expected 0", k, wave_errs(exp_f)); end
            checks++; if (fd_cnt - fd0 !== 1) begin errors++; $display("FAIL rand%0d_done: got %0d pulses expected 1", k, fd_cnt - fd0); end
        end
    endtask

`ifdef DHT11_RESP_FAULT_EN
    task automatic test_fault();
        logic [39:0] exp_f;
        hum_int = 8'h37; hum_dec = 8'h00; temp_int = 8'h19; temp_dec = 8'h05;
        fault_cksum = 1'b1;
        exp_f = model_frame(hum_int, hum_dec, temp_int, temp_dec, 1'b1);
        host_start(SMIN);
        capture();
        fault_cksum = 1'b0;
        checks++; if (decode() !== exp_f) begin errors++; $display("FAIL fault_frame: got %h expected %h", decode(), exp_f); end
        checks++; if (decode()[7:0] !== 8'hAA) begin errors++; $display("FAIL fault_ck: got %h expected aa", decode()[7:0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_short_start();
        test_cksum_wrap();
        test_snapshot();
        test_reset_mid_frame();
        test_random();
`ifdef DHT11_RESP_FAULT_EN
        test_fault();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
